// File: rtl/hbconsole_pkg.sv
// hbconsole_pkg: shared state encoding, constants and tag helper for the
// console/hexbus UART multiplexer.
package hbconsole_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HBLOCK = 2'd1,
    S_LF     = 2'd2
  } state_t;

  localparam logic [6:0] HB_NEWLINE = 7'h0a;
  localparam logic [7:0] CON_CR     = 8'h0d;
  localparam int         TAG_BIT    = 7;

  // Build a UART byte from a channel tag and a 7-bit payload
  function automatic logic [7:0] tag_byte(input logic i_is_hb, input logic [6:0] i_data);
    return {i_is_hb, i_data};
  endfunction

endpackage

// File: rtl/hbconsole_rxdemux.sv
// hbconsole_rxdemux: registered split of the UART receive stream into the
// hexbus and console channels using the tag bit.
module hbconsole_rxdemux
  import hbconsole_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_stb,
  input  logic [7:0] i_rx_data,
  output logic       o_hb_stb,
  output logic [6:0] o_hb_data,
  output logic       o_con_stb,
  output logic [6:0] o_con_data
);

  logic       r_hb_stb;
  logic [6:0] r_hb_data;
  logic       r_con_stb;
  logic [6:0] r_con_data;

  // Route each received byte to one channel; strobes last exactly one cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hb_stb   <= 1'b0;
      r_hb_data  <= '0;
      r_con_stb  <= 1'b0;
      r_con_data <= '0;
    end else begin
      r_hb_stb  <= i_rx_stb && i_rx_data[TAG_BIT];
      r_con_stb <= i_rx_stb && !i_rx_data[TAG_BIT];
      if (i_rx_stb && i_rx_data[TAG_BIT])
        r_hb_data <= i_rx_data[6:0];
      if (i_rx_stb && !i_rx_data[TAG_BIT])
        r_con_data <= i_rx_data[6:0];
    end
  end

  assign o_hb_stb   = r_hb_stb;
  assign o_hb_data  = r_hb_data;
  assign o_con_stb  = r_con_stb;
  assign o_con_data = r_con_data;

endmodule

// File: rtl/hbconsole.sv
// hbconsole: merges the console transmit stream and the hexbus response
// stream onto one tagged UART channel, and splits the receive side back.
// Hexbus words (terminated by newline) are sent atomically; a watchdog frees
// the word lock if the hexbus source stalls mid-word.
// Optional build macro HBCONSOLE_CRLF_EN expands console newline into CR LF.
module hbconsole
  import hbconsole_pkg::*;
#(
  parameter int LGWATCHDOG = 10
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_stb,
  input  logic [7:0] i_rx_data,
  output logic       o_hb_rx_stb,
  output logic [6:0] o_hb_rx_data,
  output logic       o_console_stb,
  output logic [6:0] o_console_data,
  input  logic       i_console_stb,
  input  logic [6:0] i_console_data,
  output logic       o_console_busy,
  input  logic       i_hb_stb,
  input  logic [6:0] i_hb_data,
  output logic       o_hb_busy,
  output logic       o_tx_stb,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_busy
);

  logic                  r_tx_valid;
  logic [7:0]            r_tx_data;
  state_t                r_state;
  logic [LGWATCHDOG-1:0] r_wdog;

  logic w_hb_accept;
  logic w_con_accept;
  logic w_tx_done;
  logic w_wdog_expired;

  hbconsole_rxdemux u_rxdemux (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rx_stb   (i_rx_stb),
    .i_rx_data  (i_rx_data),
    .o_hb_stb   (o_hb_rx_stb),
    .o_hb_data  (o_hb_rx_data),
    .o_con_stb  (o_console_stb),
    .o_con_data (o_console_data)
  );

  // Backpressure depends only on the output register, the state and whether
  // the hexbus is asking, so the UART busy line never reaches a source.
  assign o_hb_busy      = r_tx_valid || (r_state == S_LF);
  assign o_console_busy = r_tx_valid || (r_state != S_IDLE) || i_hb_stb;

  assign w_hb_accept    = i_hb_stb && !o_hb_busy;
  assign w_con_accept   = i_console_stb && !o_console_busy;
  assign w_tx_done      = r_tx_valid && !i_tx_busy;
  assign w_wdog_expired = (r_state == S_HBLOCK) && (&r_wdog);

  // Arbiter state machine, transmit register and word-lock watchdog
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_state    <= S_IDLE;
      r_wdog     <= '0;
    end else begin
      if (w_tx_done)
        r_tx_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_hb_accept) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= tag_byte(1'b1, i_hb_data);
            if (i_hb_data != HB_NEWLINE)
              r_state <= S_HBLOCK;
          end else if (w_con_accept) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= tag_byte(1'b0, i_console_data);
`ifdef HBCONSOLE_CRLF_EN
            if (i_console_data == HB_NEWLINE) begin
              r_tx_data <= CON_CR;
              r_state   <= S_LF;
            end
`endif
          end
        end

        S_HBLOCK: begin
          if (w_hb_accept) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= tag_byte(1'b1, i_hb_data);
            if (i_hb_data == HB_NEWLINE)
              r_state <= S_IDLE;
          end else if (w_wdog_expired) begin
            r_state <= S_IDLE;
          end
        end

        S_LF: begin
`ifdef HBCONSOLE_CRLF_EN
          if (!r_tx_valid) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= tag_byte(1'b0, HB_NEWLINE);
            r_state    <= S_IDLE;
          end
`else
          r_state <= S_IDLE;
`endif
        end

        default: r_state <= S_IDLE;
      endcase

      if ((r_state != S_HBLOCK) || w_hb_accept || w_wdog_expired)
        r_wdog <= '0;
      else if (!i_hb_stb)
        r_wdog <= r_wdog + 1'b1;
    end
  end

  assign o_tx_stb  = r_tx_valid;
  assign o_tx_data = r_tx_data;

endmodule

// File: tb/tb_hbconsole.sv
// tb_hbconsole: scoreboard bench for the console/hexbus UART multiplexer.
// Sources push expected UART bytes into per-channel queues; a negedge monitor
// pops and compares whenever the DUT hands a byte to the UART or strobes RX.
module tb_hbconsole;

  localparam int LGW    = 10;
  localparam int BUDGET = 3000;

  typedef struct {
    logic [6:0] data;
    int         cyc;
  } rxExp_t;

  logic       clk = 1'b0;
  logic       rstN;
  logic       rxStb;
  logic [7:0] rxData;
  logic       hbRxStb;
  logic [6:0] hbRxData;
  logic       conRxStb;
  logic [6:0] conRxData;
  logic       conStb;
  logic [6:0] conData;
  logic       conBusy;
  logic       hbStb;
  logic [6:0] hbData;
  logic       hbBusy;
  logic       txStb;
  logic [7:0] txData;
  logic       txBusy;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  logic [7:0] expHbTx[$];
  logic [7:0] expConTx[$];
  logic [7:0] txLog[$];
  logic [7:0] expLog[$];
  rxExp_t     expHbRx[$];
  rxExp_t     expConRx[$];

  bit inWord      = 1'b0;
  bit lockCheckEn = 1'b1;
  bit prevWasCr   = 1'b0;
  bit randDone    = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  hbconsole #(.LGWATCHDOG(LGW)) dut (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_rx_stb       (rxStb),
    .i_rx_data      (rxData),
    .o_hb_rx_stb    (hbRxStb),
    .o_hb_rx_data   (hbRxData),
    .o_console_stb  (conRxStb),
    .o_console_data (conRxData),
    .i_console_stb  (conStb),
    .i_console_data (conData),
    .o_console_busy (conBusy),
    .i_hb_stb       (hbStb),
    .i_hb_data      (hbData),
    .o_hb_busy      (hbBusy),
    .o_tx_stb       (txStb),
    .o_tx_data      (txData),
    .i_tx_busy      (txBusy)
  );

  // Single comparison point: counts every check and reports any difference
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drive one UART receive byte and record where it must reappear
  task automatic applyStimulus(input logic [7:0] b);
    rxExp_t e;
    e.data = b[6:0];
    e.cyc  = cyc + 1;
    if (b[7]) expHbRx.push_back(e);
    else      expConRx.push_back(e);
    rxData = b;
    rxStb  = 1'b1;
    @(posedge clk); #1;
    rxStb  = 1'b0;
  endtask

  // Offer a hexbus byte and hold it until the handshake completes
  task automatic sendHb(input logic [6:0] d, input bit expectIt, output int waited);
    bit done = 1'b0;
    if (expectIt) expHbTx.push_back({1'b1, d});
    hbData = d;
    hbStb  = 1'b1;
    waited = 0;
    while (!done) begin
      @(negedge clk);
      if (!hbBusy) done = 1'b1;
      else begin
        waited++;
        if (waited > BUDGET) begin
          checkOutput("hbAcceptTimeout", 32'(waited), 32'(BUDGET));
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    hbStb = 1'b0;
  endtask

  // Offer a console byte and hold it until the handshake completes
  task automatic sendCon(input logic [6:0] d, input bit expectIt, output int waited);
    bit done = 1'b0;
    if (expectIt) begin
`ifdef HBCONSOLE_CRLF_EN
      if (d == 7'h0a) begin
        expConTx.push_back(8'h0d);
        expConTx.push_back(8'h0a);
      end else
        expConTx.push_back({1'b0, d});
`else
      expConTx.push_back({1'b0, d});
`endif
    end
    conData = d;
    conStb  = 1'b1;
    waited  = 0;
    while (!done) begin
      @(negedge clk);
      if (!conBusy) done = 1'b1;
      else begin
        waited++;
        if (waited > BUDGET) begin
          checkOutput("conAcceptTimeout", 32'(waited), 32'(BUDGET));
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    conStb = 1'b0;
  endtask

  // Wait until every expected byte has left and the UART is idle
  task automatic waitDrain(input string name);
    int n = 0;
    while (!(expHbTx.size() == 0 && expConTx.size() == 0 && !txStb) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(n < 200), 32'd1);
    @(posedge clk); #1;
  endtask

  // Compare the recorded UART byte order against the expected list
  task automatic checkLog(input string name);
    checkOutput({name, "Len"}, 32'(txLog.size()), 32'(expLog.size()));
    for (int i = 0; i < expLog.size() && i < txLog.size(); i++)
      checkOutput(name, 32'(txLog[i]), 32'(expLog[i]));
    txLog.delete();
    expLog.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Scoreboard monitor: UART hand-offs and RX strobes are popped and compared
  always @(negedge clk) begin
    if (rstN) begin
      if (txStb && !txBusy) begin
        logic [7:0] e;
        txLog.push_back(txData);
`ifdef HBCONSOLE_CRLF_EN
        if (prevWasCr) checkOutput("crlfPair", 32'(txData), 32'h0a);
        prevWasCr = (txData == 8'h0d);
`endif
        if (txData[7]) begin
          if (expHbTx.size() == 0) checkOutput("spuriousHbTx", 32'(txData), 32'hffff);
          else begin
            e = expHbTx.pop_front();
            checkOutput("txHbByte", 32'(txData), 32'(e));
          end
          inWord = (txData != 8'h8a);
        end else begin
          if (expConTx.size() == 0) checkOutput("spuriousConTx", 32'(txData), 32'hffff);
          else begin
            e = expConTx.pop_front();
            checkOutput("txConByte", 32'(txData), 32'(e));
          end
          if (lockCheckEn) checkOutput("consoleInsideHbWord", 32'(inWord), 32'd0);
          inWord = 1'b0;
        end
      end
      if (hbRxStb) begin
        rxExp_t r;
        if (expHbRx.size() == 0) checkOutput("spuriousHbRx", 32'(hbRxData), 32'hffff);
        else begin
          r = expHbRx.pop_front();
          checkOutput("hbRxData", 32'(hbRxData), 32'(r.data));
          checkOutput("hbRxCycle", 32'(cyc), 32'(r.cyc));
        end
      end
      if (conRxStb) begin
        rxExp_t r;
        if (expConRx.size() == 0) checkOutput("spuriousConRx", 32'(conRxData), 32'hffff);
        else begin
          r = expConRx.pop_front();
          checkOutput("conRxData", 32'(conRxData), 32'(r.data));
          checkOutput("conRxCycle", 32'(cyc), 32'(r.cyc));
        end
      end
    end
  end

  // Random hexbus source: newline-terminated words with short gaps
  task automatic randHb();
    int w;
    logic [6:0] d;
    for (int k = 0; k < 30; k++) begin
      int len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++) begin
        do d = 7'($urandom); while (d == 7'h0a);
        sendHb(d, 1'b1, w);
        idle($urandom_range(0, 3));
      end
      sendHb(7'h0a, 1'b1, w);
      idle($urandom_range(0, 6));
    end
  endtask

  // Random console source: occasional newlines, never a bare CR
  task automatic randCon();
    int w;
    logic [6:0] d;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 7) == 0) d = 7'h0a;
      else do d = 7'($urandom); while (d == 7'h0d);
      sendCon(d, 1'b1, w);
      idle($urandom_range(0, 4));
    end
  endtask

  // Random UART receive traffic running alongside the transmit side
  task automatic randRx();
    for (int k = 0; k < 80; k++) begin
      applyStimulus(8'($urandom));
      idle($urandom_range(0, 3));
    end
  endtask

  initial begin
    int w, wc;
    rstN = 1'b0; rxStb = 1'b0; rxData = '0;
    conStb = 1'b0; conData = '0; hbStb = 1'b0; hbData = '0; txBusy = 1'b0;
    #12;
    // Reset values
    checkOutput("rstTxStb", 32'(txStb), 32'd0);
    checkOutput("rstTxData", 32'(txData), 32'd0);
    checkOutput("rstHbRxStb", 32'(hbRxStb), 32'd0);
    checkOutput("rstHbRxData", 32'(hbRxData), 32'd0);
    checkOutput("rstConRxStb", 32'(conRxStb), 32'd0);
    checkOutput("rstConRxData", 32'(conRxData), 32'd0);
    checkOutput("rstHbBusy", 32'(hbBusy), 32'd0);
    checkOutput("rstConBusyIdle", 32'(conBusy), 32'd0);
    hbStb = 1'b1; #1;
    checkOutput("rstConBusyFollowsHb", 32'(conBusy), 32'd1);
    hbStb = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    idle(2);

    $display("[TB] RX split");
    applyStimulus(8'hc1);
    applyStimulus(8'h41);
    idle(3);

    $display("[TB] Hexbus word lock against waiting console");
    fork
      begin sendHb(7'h31, 1'b1, w); sendHb(7'h32, 1'b1, w); sendHb(7'h0a, 1'b1, w); end
      sendCon(7'h58, 1'b1, wc);
    join
    waitDrain("wordLockDrain");
    expLog = '{8'hb1, 8'hb2, 8'h8a, 8'h58};
    checkLog("wordLockOrder");

    $display("[TB] UART backpressure");
    txBusy = 1'b1;
    sendHb(7'h31, 1'b1, w);
    repeat (20) begin
      @(negedge clk);
      checkOutput("bpTxStb", 32'(txStb), 32'd1);
      checkOutput("bpTxData", 32'(txData), 32'hb1);
      checkOutput("bpHbBusy", 32'(hbBusy), 32'd1);
    end
    @(posedge clk); #1;
    txBusy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bpTxStbAfterAccept", 32'(txStb), 32'd0);
    @(posedge clk); #1;
    sendHb(7'h0a, 1'b1, w);
    waitDrain("bpDrain");
    txLog.delete();

    $display("[TB] Watchdog release");
    lockCheckEn = 1'b0;
    fork
      sendHb(7'h31, 1'b1, w);
      sendCon(7'h58, 1'b1, wc);
    join
    checkOutput("wdogReleaseWindow", 32'((wc >= (1 << LGW) - 2) && (wc <= (1 << LGW) + 4)), 32'd1);
    waitDrain("wdogDrain");
    expLog = '{8'hb1, 8'h58};
    checkLog("wdogOrder");
    lockCheckEn = 1'b1;

    $display("[TB] Console newline");
    sendCon(7'h0a, 1'b1, w);
    waitDrain("nlDrain");
`ifdef HBCONSOLE_CRLF_EN
    expLog = '{8'h0d, 8'h0a};
`else
    expLog = '{8'h0a};
`endif
    checkLog("nlOrder");

    $display("[TB] Reset mid-transfer");
    txBusy = 1'b1;
    sendHb(7'h31, 1'b0, w);
    @(negedge clk); #2;
    rstN = 1'b0;
    #1;
    checkOutput("midRstTxStb", 32'(txStb), 32'd0);
    checkOutput("midRstTxData", 32'(txData), 32'd0);
    checkOutput("midRstHbBusy", 32'(hbBusy), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rstN = 1'b1;
    txBusy = 1'b0;
    idle(4);
    sendCon(7'h41, 1'b1, w);
    checkOutput("postRstConWait", 32'(w), 32'd0);
    waitDrain("postRstDrain");
    expLog = '{8'h41};
    checkLog("postRstOrder");

    $display("[TB] Randomized traffic");
    fork
      begin
        fork
          randHb();
          randCon();
          randRx();
        join
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(posedge clk); #1;
          txBusy = ($urandom_range(0, 2) == 0);
        end
        txBusy = 1'b0;
      end
    join
    waitDrain("randDrain");
    idle(3);
    checkOutput("hbTxLeft", 32'(expHbTx.size()), 32'd0);
    checkOutput("conTxLeft", 32'(expConTx.size()), 32'd0);
    checkOutput("hbRxLeft", 32'(expHbRx.size()), 32'd0);
    checkOutput("conRxLeft", 32'(expConRx.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
